// File: rtl/uart_rx_os16.sv
// 8N1 serial receiver with 16x oversampling on a free-running tick.
// Delivers each good byte as a one-cycle strobe; bad stop bits raise frame_err.
module uart_rx_os16 #(
    parameter int TICK_DIV   = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 sample_tick,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic                 rx_meta_r;
    logic                 rx_s;
    logic [DIV_W-1:0]     div_cnt_r;
    logic [DIV_W-1:0]     div_nxt_s;
    logic [2:0]           state_r;
    logic [2:0]           state_nxt_s;
    logic [OS_W-1:0]      os_cnt_r;
    logic [OS_W-1:0]      os_nxt_s;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [BIT_W-1:0]     bit_nxt_s;
    logic [DATA_BITS-1:0] shreg_r;
    logic [DATA_BITS-1:0] shreg_nxt_s;
    logic                 load_s;
    logic                 err_s;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s      <= rx_meta_r;
        end
    end

    // Divider wrap value; with TICK_DIV=1 the counter sits at zero.
    always_comb begin
        if (div_cnt_r == DIV_LAST) begin
            div_nxt_s = {DIV_W{1'b0}};
        end else begin
            div_nxt_s = div_cnt_r + DIV_ONE;
        end
    end

    // Free-running divider; the tick flop is pre-decoded so it is high exactly when div_cnt is at its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_r   <= {DIV_W{1'b0}};
            sample_tick <= 1'b0;
        end else begin
            div_cnt_r   <= div_nxt_s;
            sample_tick <= (div_nxt_s == DIV_LAST);
        end
    end

    // Frame sequencing; nothing moves except on a sample tick.
    always_comb begin
        state_nxt_s = state_r;
        os_nxt_s    = os_cnt_r;
        bit_nxt_s   = bit_cnt_r;
        shreg_nxt_s = shreg_r;
        load_s      = 1'b0;
        err_s       = 1'b0;
        if (sample_tick) begin
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt_s = START;
                        os_nxt_s    = {OS_W{1'b0}};
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                START: begin
                    if (os_cnt_r == OS_MID) begin
                        os_nxt_s  = {OS_W{1'b0}};
                        bit_nxt_s = {BIT_W{1'b0}};
                        if (!rx_s) begin
                            state_nxt_s = DATA;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        os_nxt_s = os_cnt_r + OS_ONE;
                    end
                end
                DATA: begin
                    if (os_cnt_r == OS_LAST) begin
                        os_nxt_s    = {OS_W{1'b0}};
                        shreg_nxt_s = {rx_s, shreg_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == BIT_LAST) begin
                            state_nxt_s = STOP;
                        end else begin
                            bit_nxt_s = bit_cnt_r + BIT_ONE;
                        end
                    end else begin
                        os_nxt_s = os_cnt_r + OS_ONE;
                    end
                end
                STOP: begin
                    if (os_cnt_r == OS_LAST) begin
                        os_nxt_s = {OS_W{1'b0}};
                        if (rx_s) begin
                            load_s      = 1'b1;
                            state_nxt_s = IDLE;
                        end else begin
                            err_s       = 1'b1;
                            state_nxt_s = BREAK;
                        end
                    end else begin
                        os_nxt_s = os_cnt_r + OS_ONE;
                    end
                end
                BREAK: begin
                    // A held-low line must return high before another start bit can count.
                    if (rx_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = BREAK;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, counters and registered output strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            os_cnt_r   <= {OS_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            shreg_r    <= {DATA_BITS{1'b0}};
            data       <= {DATA_BITS{1'b0}};
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            os_cnt_r   <= os_nxt_s;
            bit_cnt_r  <= bit_nxt_s;
            shreg_r    <= shreg_nxt_s;
            data_valid <= load_s;
            frame_err  <= err_s;
            busy       <= (state_nxt_s != IDLE);
            if (load_s) begin
                data <= shreg_r;
            end else begin
                data <= data;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: one instance at 432 clk/bit, one at TICK_DIV=1 (16 clk/bit).
// A queue of expected frame outcomes is checked against the outputs on every cycle.
module tb_uart_rx_os16;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       tick_a, valid_a, err_a, busy_a;
    logic       tick_b, valid_b, err_b, busy_b;
    logic [7:0] data_a, data_b;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic rst_q = 1'b1;
    int q_a[$];
    int q_b[$];
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;
    logic prev_tick_a = 1'b0, prev_tick_b = 1'b0;
    logic prev_busy_a = 1'b0;
    int cnt_valid_a = 0, cnt_err_a = 0, cnt_valid_b = 0, cnt_err_b = 0;
    int busy_rise_a = 0;
    int r0;

    uart_rx_os16 dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .sample_tick(tick_a),
        .data(data_a), .data_valid(valid_a), .frame_err(err_a), .busy(busy_a)
    );

    uart_rx_os16 #(.TICK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .sample_tick(tick_b),
        .data(data_b), .data_valid(valid_b), .frame_err(err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Clocks since the last reset edge; tick is due every TICK_DIV-th one.
    always @(posedge clk) begin
        rst_q <= !rst_n;
        cyc   <= !rst_n ? 0 : cyc + 1;
    end

    always @(negedge clk) begin
        int e;
        if (rst_q) begin
            last_a = 8'h00;
            last_b = 8'h00;
            prev_tick_a = 1'b0;
            prev_tick_b = 1'b0;
        end
        chk("tick_a", tick_a, !rst_q && (cyc % 27 == 26));
        chk("tick_b", tick_b, !rst_q);
        chk("excl_a", valid_a & err_a, 1'b0);
        chk("excl_b", valid_b & err_b, 1'b0);
        if (valid_a) begin
            cnt_valid_a++;
            chk("latency_a", prev_tick_a, 1'b1);
            if (q_a.size() == 0) chk("spurious_valid_a", valid_a, 1'b0);
            else begin
                e = q_a.pop_front();
                if (e < 0) chk("valid_instead_of_err_a", valid_a, 1'b0);
                else begin
                    chk("data_a", data_a, e);
                    last_a = 8'(e);
                end
            end
        end else begin
            chk("hold_a", data_a, last_a);
        end
        if (err_a) begin
            cnt_err_a++;
            if (q_a.size() == 0 || q_a[0] >= 0) chk("spurious_err_a", err_a, 1'b0);
            else e = q_a.pop_front();
        end
        if (valid_b) begin
            cnt_valid_b++;
            chk("latency_b", prev_tick_b, 1'b1);
            if (q_b.size() == 0) chk("spurious_valid_b", valid_b, 1'b0);
            else begin
                e = q_b.pop_front();
                chk("data_b", data_b, e);
                last_b = 8'(e);
            end
        end else begin
            chk("hold_b", data_b, last_b);
        end
        if (err_b) begin
            cnt_err_b++;
            chk("spurious_err_b", err_b, 1'b0);
        end
        if (busy_a && !prev_busy_a) busy_rise_a++;
        prev_busy_a = busy_a;
        prev_tick_a = tick_a;
        prev_tick_b = tick_b;
    end

    task automatic drive(input bit which, input logic v, input int n);
        if (which) rx_b = v;
        else rx_a = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit which, input logic [7:0] b, input logic stop_val, input int stop_bits);
        int bp;
        bp = which ? 16 : 432;
        drive(which, 1'b0, bp);
        for (int i = 0; i < 8; i++) drive(which, b[i], bp);
        drive(which, stop_val, bp * stop_bits);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tick_a", tick_a, 1'b0);
        chk("rst_data_a", data_a, 8'h00);
        chk("rst_valid_a", valid_a, 1'b0);
        chk("rst_err_a", err_a, 1'b0);
        chk("rst_busy_a", busy_a, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;

        // 0xA5 with one idle bit before it
        drive(1'b0, 1'b1, 432);
        q_a.push_back(8'hA5);
        send_frame(1'b0, 8'hA5, 1'b1, 1);
        chk("a5_data", data_a, 8'hA5);
        chk("a5_count", cnt_valid_a, 1);
        chk("a5_busy", busy_a, 1'b0);
        chk("a5_err", cnt_err_a, 0);

        // Short low glitch: rejected at mid start bit
        r0 = busy_rise_a;
        drive(1'b0, 1'b0, 81);
        drive(1'b0, 1'b1, 540);
        chk("glitch_busy_pulse", busy_rise_a - r0, 1);
        chk("glitch_busy_end", busy_a, 1'b0);
        chk("glitch_data", data_a, 8'hA5);
        chk("glitch_count", cnt_valid_a, 1);

        // 0x3C with stop held low for two bit periods
        q_a.push_back(-1);
        send_frame(1'b0, 8'h3C, 1'b0, 2);
        drive(1'b0, 1'b1, 864);
        chk("ferr_count", cnt_err_a, 1);
        chk("ferr_data", data_a, 8'hA5);
        chk("ferr_busy", busy_a, 1'b0);

        // Recovery plus back-to-back frames at 432 clk/bit
        q_a.push_back(8'h81);
        q_a.push_back(8'h42);
        q_a.push_back(8'hC3);
        send_frame(1'b0, 8'h81, 1'b1, 1);
        chk("rx81_data", data_a, 8'h81);
        send_frame(1'b0, 8'h42, 1'b1, 1);
        send_frame(1'b0, 8'hC3, 1'b1, 1);
        chk("b2b_data", data_a, 8'hC3);
        chk("b2b_count", cnt_valid_a, 4);

        // Reset in the middle of the data bits of 0xFF
        drive(1'b0, 1'b1, 432);
        drive(1'b0, 1'b0, 432);
        drive(1'b0, 1'b1, 3 * 432);
        chk("pre_rst_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 6 * 432);
        chk("aborted_count", cnt_valid_a, 4);
        chk("aborted_busy", busy_a, 1'b0);
        drive(1'b0, 1'b1, 432);
        q_a.push_back(8'h5A);
        send_frame(1'b0, 8'h5A, 1'b1, 1);
        drive(1'b0, 1'b1, 432);
        chk("rx5a_data", data_a, 8'h5A);
        chk("rx5a_count", cnt_valid_a, 5);

        // TICK_DIV=1: 60 back-to-back bytes, then 0x96 after one idle bit
        for (int i = 0; i < 60; i++) q_b.push_back(i);
        for (int i = 0; i < 60; i++) send_frame(1'b1, 8'(i), 1'b1, 1);
        chk("burst_count", cnt_valid_b, 60);
        chk("burst_last", data_b, 8'h3B);
        drive(1'b1, 1'b1, 16);
        q_b.push_back(8'h96);
        send_frame(1'b1, 8'h96, 1'b1, 1);
        drive(1'b1, 1'b1, 32);
        chk("rx96_data", data_b, 8'h96);
        chk("rx96_count", cnt_valid_b, 61);
        chk("b_errs", cnt_err_b, 0);
        chk("b_busy", busy_b, 1'b0);

        chk("drained_a", q_a.size(), 0);
        chk("drained_b", q_b.size(), 0);
        chk("total_err_a", cnt_err_a, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
